// File: rtl/ep_result_pipe_pkg.sv
// Shared constants and the default-width stage record for the even-pipe result staging pipeline.
package ep_result_pipe_pkg;

    localparam int EP_DEPTH   = 7;
    localparam int EP_ADDR_W  = 7;
    localparam int EP_DATA_W  = 128;
    localparam int EP_LAT_W   = 3;
    localparam int EP_NUM_SRC = 3;

    // Age is implied by the stage index, so it is not stored.
    typedef struct packed {
        logic                 valid;
        logic                 wr_en;
        logic [EP_ADDR_W-1:0] rt_addr;
        logic [EP_DATA_W-1:0] value;
        logic [EP_LAT_W-1:0]  lat;
    } ep_stage_t;

endpackage

// File: rtl/ep_result_pipe_if.sv
// Issue, forwarding-lookup and writeback bundle of the even-pipe result staging pipeline.
interface ep_result_pipe_if
    import ep_result_pipe_pkg::*;
#(
    parameter int DATA_W  = EP_DATA_W,
    parameter int ADDR_W  = EP_ADDR_W,
    parameter int LAT_W   = EP_LAT_W,
    parameter int NUM_SRC = EP_NUM_SRC
) ();

    logic                      stall;
    logic                      flush;
    logic [LAT_W-1:0]          flush_depth;
    logic                      in_valid;
    logic                      in_wr_en;
    logic [ADDR_W-1:0]         in_rt_addr;
    logic [DATA_W-1:0]         in_value;
    logic [LAT_W-1:0]          in_lat;
    logic [NUM_SRC*ADDR_W-1:0] src_addr;
    logic [NUM_SRC-1:0]        fwd_hit;
    logic [NUM_SRC*DATA_W-1:0] fwd_data;
    logic                      fwd_stall;
    logic                      wb_valid;
    logic                      wb_wr_en;
    logic [ADDR_W-1:0]         wb_rt_addr;
    logic [DATA_W-1:0]         wb_value;
    logic [31:0]               stat_hits;
    logic [31:0]               stat_stalls;

    modport master (
        output stall, flush, flush_depth, in_valid, in_wr_en, in_rt_addr, in_value, in_lat,
               src_addr,
        input  fwd_hit, fwd_data, fwd_stall, wb_valid, wb_wr_en, wb_rt_addr, wb_value,
               stat_hits, stat_stalls
    );

    modport slave (
        input  stall, flush, flush_depth, in_valid, in_wr_en, in_rt_addr, in_value, in_lat,
               src_addr,
        output fwd_hit, fwd_data, fwd_stall, wb_valid, wb_wr_en, wb_rt_addr, wb_value,
               stat_hits, stat_stalls
    );

endinterface

// File: rtl/ep_fwd_select.sv
// Youngest-first forwarding match for one source register across all in-flight stages.
module ep_fwd_select
    import ep_result_pipe_pkg::*;
#(
    parameter int DATA_W = EP_DATA_W,
    parameter int ADDR_W = EP_ADDR_W,
    parameter int DEPTH  = EP_DEPTH
) (
    input  logic [ADDR_W-1:0]             src,
    input  logic [DEPTH-1:0]              valid,
    input  logic [DEPTH-1:0]              wr_en,
    input  logic [DEPTH-1:0]              ready,
    input  logic [DEPTH-1:0][ADDR_W-1:0]  rt_addr,
    input  logic [DEPTH-1:0][DATA_W-1:0]  value,
    output logic                          hit,
    output logic                          pend,
    output logic [DATA_W-1:0]             data
);

    logic found;

    // Index 0 is stage 1 (youngest); once found, older matches are shadowed even if ready.
    always_comb begin
        hit   = 1'b0;
        pend  = 1'b0;
        data  = '0;
        found = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!found && valid[k] && wr_en[k] && (rt_addr[k] == src)) begin
                found = 1'b1;
                if (ready[k]) begin
                    hit  = 1'b1;
                    data = value[k];
                end else begin
                    pend = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ep_result_pipe.sv
// Parametrised even-pipe result staging pipeline with operand forwarding and RAW stall detection.
// Optional forwarding statistics counters are built when EP_FWD_STATS_EN is defined.
module ep_result_pipe
    import ep_result_pipe_pkg::*;
#(
    parameter int DATA_W  = EP_DATA_W,
    parameter int ADDR_W  = EP_ADDR_W,
    parameter int DEPTH   = EP_DEPTH,
    parameter int LAT_W   = EP_LAT_W,
    parameter int NUM_SRC = EP_NUM_SRC
) (
    input  logic              clock,
    input  logic              reset,
    ep_result_pipe_if.slave   bus
);

    logic [DEPTH-1:0]              stg_vld;
    logic [DEPTH-1:0]              stg_wr;
    logic [DEPTH-1:0][ADDR_W-1:0]  stg_addr;
    logic [DEPTH-1:0][DATA_W-1:0]  stg_val;
    logic [DEPTH-1:0][LAT_W-1:0]   stg_lat;
    logic [DEPTH-1:0]              rdy;
    logic [DEPTH-1:0]              kill;

    logic                          wb_vld;
    logic                          wb_wr;
    logic [ADDR_W-1:0]             wb_addr;
    logic [DATA_W-1:0]             wb_val;

    logic [NUM_SRC-1:0]            hit;
    logic [NUM_SRC-1:0]            pend;
    logic [NUM_SRC*DATA_W-1:0]     fwd_data;

    function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
        if (lat == '0)
            return LAT_W'(1);
        if (lat > LAT_W'(DEPTH))
            return LAT_W'(DEPTH);
        return lat;
    endfunction

    // Stage k+1 has age k+1; flush kills the entries in stages 1..flush_depth as they shift.
    always_comb begin
        rdy  = '0;
        kill = '0;
        for (int k = 0; k < DEPTH; k++) begin
            rdy[k]  = (LAT_W'(k + 1) >= stg_lat[k]);
            kill[k] = bus.flush && (k < int'(bus.flush_depth));
        end
    end

    // Stage 1..DEPTH valid bits and registered writeback
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stg_vld <= '0;
            wb_vld  <= 1'b0;
            wb_wr   <= 1'b0;
            wb_addr <= '0;
            wb_val  <= '0;
        end else if (bus.stall) begin
            wb_vld <= 1'b0;
        end else begin
            stg_vld[0] <= bus.in_valid && !bus.flush;
            for (int k = 1; k < DEPTH; k++)
                stg_vld[k] <= stg_vld[k-1] && !kill[k-1];
            wb_vld  <= stg_vld[DEPTH-1] && !kill[DEPTH-1];
            wb_wr   <= stg_vld[DEPTH-1] && !kill[DEPTH-1] && stg_wr[DEPTH-1];
            wb_addr <= stg_addr[DEPTH-1];
            wb_val  <= stg_val[DEPTH-1];
        end
    end

    // Stage payloads are qualified by stg_vld, so they need no reset
    always_ff @(posedge clock) begin
        if (!bus.stall) begin
            stg_wr[0]   <= bus.in_wr_en;
            stg_addr[0] <= bus.in_rt_addr;
            stg_val[0]  <= bus.in_value;
            stg_lat[0]  <= clamp_lat(bus.in_lat);
            for (int k = 1; k < DEPTH; k++) begin
                stg_wr[k]   <= stg_wr[k-1];
                stg_addr[k] <= stg_addr[k-1];
                stg_val[k]  <= stg_val[k-1];
                stg_lat[k]  <= stg_lat[k-1];
            end
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        ep_fwd_select #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_sel (
            .src     (bus.src_addr[(NUM_SRC-1-s)*ADDR_W +: ADDR_W]),
            .valid   (stg_vld),
            .wr_en   (stg_wr),
            .ready   (rdy),
            .rt_addr (stg_addr),
            .value   (stg_val),
            .hit     (hit[s]),
            .pend    (pend[s]),
            .data    (fwd_data[(NUM_SRC-1-s)*DATA_W +: DATA_W])
        );
    end

    assign bus.fwd_hit    = hit;
    assign bus.fwd_data   = fwd_data;
    assign bus.fwd_stall  = |pend;
    assign bus.wb_valid   = wb_vld;
    assign bus.wb_wr_en   = wb_wr;
    assign bus.wb_rt_addr = wb_addr;
    assign bus.wb_value   = wb_val;

`ifdef EP_FWD_STATS_EN
    logic [31:0] hits_cnt;
    logic [31:0] stalls_cnt;

    function automatic logic [31:0] popcount(input logic [NUM_SRC-1:0] v);
        logic [31:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_SRC; i++)
            cnt = cnt + 32'(v[i]);
        return cnt;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? '1 : sum[31:0];
    endfunction

    // Counters sample every edge, stalled or not
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hits_cnt   <= '0;
            stalls_cnt <= '0;
        end else begin
            hits_cnt <= sat_add(hits_cnt, popcount(hit));
            if (|pend)
                stalls_cnt <= sat_add(stalls_cnt, 32'd1);
        end
    end

    assign bus.stat_hits   = hits_cnt;
    assign bus.stat_stalls = stalls_cnt;
`else
    assign bus.stat_hits   = '0;
    assign bus.stat_stalls = '0;
`endif

endmodule

// File: tb/tb_ep_result_pipe.sv
// Directed bench for ep_result_pipe: forwarding priority, latency, stall, flush, async reset, stats.
module tb_ep_result_pipe;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    ep_result_pipe_if bus ();

    ep_result_pipe dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic [6:0] rt, input logic [127:0] v, input logic [2:0] lat);
        bus.in_valid   = 1'b1;
        bus.in_wr_en   = 1'b1;
        bus.in_rt_addr = rt;
        bus.in_value   = v;
        bus.in_lat     = lat;
    endtask

    task automatic set_src(input int s, input logic [6:0] a);
        bus.src_addr[(2-s)*7 +: 7] = a;
    endtask

    task automatic clear_src();
        for (int s = 0; s < 3; s++)
            set_src(s, 7'h7F);
    endtask

    function automatic logic [127:0] fdata(input int s);
        return bus.fwd_data[(2-s)*128 +: 128];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.flush_depth = '0;
        bus.in_valid = 1'b0;
        bus.in_wr_en = 1'b0;
        bus.in_rt_addr = '0;
        bus.in_value = '0;
        bus.in_lat = '0;
        bus.src_addr = '0;
        #3;
        check("rst_wb_valid", bus.wb_valid, 0);
        check("rst_fwd_hit", bus.fwd_hit, 0);
        check("rst_fwd_stall", bus.fwd_stall, 0);
        check("rst_stat_hits", bus.stat_hits, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        clear_src();

        // single issue, lat 2: stall, then hit, then writeback 8 edges later
        issue(7'd5, 128'h1E, 3'd2);
        set_src(0, 7'd5);
        tick();
        bus.in_valid = 1'b0;
        check("t1_stall", bus.fwd_stall, 1);
        check("t1_hit_early", bus.fwd_hit[0], 0);
        tick();
        check("t1_hit", bus.fwd_hit[0], 1);
        check("t1_data", fdata(0), 128'h1E);
        check("t1_stall_clear", bus.fwd_stall, 0);
        repeat (5) tick();
        check("t1_wb_early", bus.wb_valid, 0);
        tick();
        check("t1_wb_valid", bus.wb_valid, 1);
        check("t1_wb_addr", bus.wb_rt_addr, 5);
        check("t1_wb_value", bus.wb_value, 128'h1E);
        check("t1_wb_wr_en", bus.wb_wr_en, 1);
        clear_src();
        tick();
        check("t1_wb_drop", bus.wb_valid, 0);

        // in_lat 0 clamps to 1: ready one edge after issue
        issue(7'd3, 128'h77, 3'd0);
        set_src(1, 7'd3);
        tick();
        bus.in_valid = 1'b0;
        check("clamp_hit", bus.fwd_hit[1], 1);
        check("clamp_data", fdata(1), 128'h77);
        check("clamp_stall", bus.fwd_stall, 0);
        check("nomatch_data", fdata(2), 0);
        repeat (8) tick();
        clear_src();

        // younger unready producer shadows an older ready one
        issue(7'd9, 128'hA, 3'd1);
        tick();
        issue(7'd9, 128'hB, 3'd6);
        tick();
        bus.in_valid = 1'b0;
        set_src(0, 7'd9);
        settle();
        for (int i = 0; i < 5; i++) begin
            check("b2b_stall", bus.fwd_stall, 1);
            check("b2b_hit", bus.fwd_hit[0], 0);
            check("b2b_data", fdata(0), 0);
            tick();
        end
        check("b2b_hit_b", bus.fwd_hit[0], 1);
        check("b2b_data_b", fdata(0), 128'hB);
        tick();
        check("b2b_wb_a", bus.wb_value, 128'hA);
        check("b2b_wb_a_vld", bus.wb_valid, 1);
        tick();
        check("b2b_wb_b", bus.wb_value, 128'hB);
        clear_src();

        // flush_depth 0 kills only the input
        issue(7'd20, 128'h20, 3'd1);
        tick();
        issue(7'd21, 128'h21, 3'd1);
        bus.flush = 1'b1;
        bus.flush_depth = 3'd0;
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        set_src(0, 7'd20);
        set_src(1, 7'd21);
        settle();
        check("fd0_keep", bus.fwd_hit[0], 1);
        check("fd0_kill_in", bus.fwd_hit[1], 0);
        repeat (8) tick();
        clear_src();

        // 3-cycle stall mid-flight
        issue(7'd11, 128'h11, 3'd1);
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        issue(7'd12, 128'h12, 3'd5);
        tick();
        bus.in_valid = 1'b0;
        repeat (2) tick();
        set_src(0, 7'd12);
        settle();
        check("stl_pre_stall", bus.fwd_stall, 1);
        bus.stall = 1'b1;
        issue(7'd13, 128'h13, 3'd1);
        set_src(1, 7'd13);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stl_wb_valid", bus.wb_valid, 0);
            check("stl_frozen", bus.fwd_stall, 1);
            check("stl_in_ignored", bus.fwd_hit[1], 0);
        end
        bus.stall = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("stl_wb11_vld", bus.wb_valid, 1);
        check("stl_wb11_addr", bus.wb_rt_addr, 11);
        check("stl_still_pend", bus.fwd_stall, 1);
        tick();
        check("stl_hit12", bus.fwd_hit[0], 1);
        check("stl_data12", fdata(0), 128'h12);
        repeat (2) tick();
        check("stl_wb12_early", bus.wb_valid, 0);
        tick();
        check("stl_wb12_vld", bus.wb_valid, 1);
        check("stl_wb12_addr", bus.wb_rt_addr, 12);
        tick();
        check("stl_no_wb13", bus.wb_valid, 0);
        clear_src();

        // flush depth 2 with rt 1..4 in flight
        for (int k = 1; k <= 4; k++) begin
            issue(7'(k), 128'h100 + 128'(k), 3'd1);
            tick();
        end
        issue(7'd7, 128'h107, 3'd1);
        bus.flush = 1'b1;
        bus.flush_depth = 3'd2;
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        set_src(0, 7'd3);
        set_src(1, 7'd1);
        set_src(2, 7'd7);
        settle();
        check("fl_kill3", bus.fwd_hit[0], 0);
        check("fl_keep1", bus.fwd_hit[1], 1);
        check("fl_keep1_data", fdata(1), 128'h101);
        check("fl_kill_in", bus.fwd_hit[2], 0);
        repeat (3) tick();
        check("fl_wb1_vld", bus.wb_valid, 1);
        check("fl_wb1_addr", bus.wb_rt_addr, 1);
        tick();
        check("fl_wb2_vld", bus.wb_valid, 1);
        check("fl_wb2_addr", bus.wb_rt_addr, 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_no_wb", bus.wb_valid, 0);
        end
        clear_src();

        // async reset with the pipe full
        for (int k = 0; k < 8; k++) begin
            issue(7'(30 + k), 128'h200 + 128'(k), (k == 7) ? 3'd4 : 3'd1);
            tick();
        end
        bus.in_valid = 1'b0;
        set_src(0, 7'd37);
        set_src(1, 7'd31);
        settle();
        check("ar_pre_wb", bus.wb_valid, 1);
        check("ar_pre_stall", bus.fwd_stall, 1);
        check("ar_pre_hit", bus.fwd_hit[1], 1);
        rst = 1'b1;
        #1;
        check("ar_wb_valid", bus.wb_valid, 0);
        check("ar_wb_wr_en", bus.wb_wr_en, 0);
        check("ar_wb_addr", bus.wb_rt_addr, 0);
        check("ar_wb_value", bus.wb_value, 0);
        check("ar_fwd_hit", bus.fwd_hit, 0);
        check("ar_fwd_stall", bus.fwd_stall, 0);
        check("ar_fwd_data", bus.fwd_data[127:0], 0);
        check("ar_stat_hits", bus.stat_hits, 0);
        check("ar_stat_stalls", bus.stat_stalls, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("ar_no_stale_wb", bus.wb_valid, 0);
        end
        clear_src();

        // three sources hitting one ready entry for 4 edges, then 2 stall edges
        issue(7'd40, 128'h40, 3'd1);
        tick();
        bus.in_valid = 1'b0;
        for (int s = 0; s < 3; s++)
            set_src(s, 7'd40);
        settle();
        check("st_hit_all", bus.fwd_hit, 3'b111);
        repeat (4) tick();
        clear_src();
        settle();
`ifdef EP_FWD_STATS_EN
        check("st_hits12", bus.stat_hits, 12);
`else
        check("st_hits0", bus.stat_hits, 0);
`endif
        issue(7'd41, 128'h41, 3'd3);
        tick();
        bus.in_valid = 1'b0;
        set_src(0, 7'd41);
        settle();
        repeat (2) tick();
        clear_src();
`ifdef EP_FWD_STATS_EN
        check("st_stalls2", bus.stat_stalls, 2);
        check("st_hits_hold", bus.stat_hits, 12);
`else
        check("st_stalls0", bus.stat_stalls, 0);
        check("st_hits_hold0", bus.stat_hits, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
